// File: rtl/pixel_write_pkg.sv
// Shared definitions for the pixel write FIFO: entry layout, FSM states and
// the pixel_active to byte-enable mapping.
// Optional feature macro: PIXEL_WRITE_FIFO_Z_EN (adds Z storage and Z writes).
package pixel_write_pkg;

  localparam int ADDR_W    = 29;
  localparam int PAIR_W    = 64;

  // Entry field offsets, packed as {z_write, pixel_active, z, z_address, color, color_address}
  localparam int CADDR_LSB = 0;
  localparam int COLOR_LSB = CADDR_LSB + ADDR_W;
`ifdef PIXEL_WRITE_FIFO_Z_EN
  localparam int ZADDR_LSB  = COLOR_LSB + PAIR_W;
  localparam int Z_LSB      = ZADDR_LSB + ADDR_W;
  localparam int ACTIVE_LSB = Z_LSB + PAIR_W;
  localparam int ZWRITE_LSB = ACTIVE_LSB + 2;
  localparam int ENTRY_W    = ZWRITE_LSB + 1;
`else
  // Z fields are not stored at all when Z writes are compiled out
  localparam int ACTIVE_LSB = COLOR_LSB + PAIR_W;
  localparam int ENTRY_W    = ACTIVE_LSB + 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_COLOR,
    S_Z
  } state_t;

  // Each pixel owns one 32-bit half of the 64-bit word
  function automatic logic [7:0] byteenable_from_active(input logic [1:0] pixel_active);
    return {{4{pixel_active[1]}}, {4{pixel_active[0]}}};
  endfunction

endpackage

// File: rtl/pixel_entry_fifo.sv
// Single-clock entry FIFO with scfifo-compatible behaviour: non-showahead
// (q valid one cycle after rdreq), asynchronous clear, and protected against
// writes while full and reads while empty. usedw wraps to 0 when full.
module pixel_entry_fifo #(
  parameter int WIDTH      = 95,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2-1:0] usedw
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_en;
  logic                  rd_en;

  assign wr_en = wrreq && !full;
  assign rd_en = rdreq && !empty;
  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign usedw = count[DEPTH_LOG2-1:0];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  // Registered read port: one cycle of read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (rd_en) q <= mem[rd_ptr];
  end

endmodule

// File: rtl/pixel_write_fifo.sv
// Buffers Z-surviving pixel pairs and drains them to SDRAM as 64-bit
// Avalon-MM writes with per-pixel byte enables.
// Optional feature macro: PIXEL_WRITE_FIFO_Z_EN (second write of the Z pair).
module pixel_write_fifo
  import pixel_write_pkg::*;
#(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enqueue,
  input  logic [28:0]                color_address,
  input  logic [63:0]                color,
  input  logic [28:0]                z_address,
  input  logic [63:0]                z,
  input  logic [1:0]                 pixel_active,
  input  logic                       z_write,
  output logic [FIFO_DEPTH_LOG2-1:0] size,
  output logic                       idle,
  output logic                       overflow,
  output logic [28:0]                write_address,
  output logic [63:0]                write_writedata,
  output logic [7:0]                 write_byteenable,
  output logic                       write_write,
  input  logic                       write_waitrequest
);

  logic [ENTRY_W-1:0] fifo_data;
  logic [ENTRY_W-1:0] fifo_q;
  logic               fifo_rdreq;
  logic               fifo_empty;
  logic               fifo_full;
  logic [1:0]         fetch_active;
  state_t             state;
  state_t             state_nxt;

  logic [28:0]        ent_color_address;
  logic [63:0]        ent_color;
  logic [7:0]         ent_byteenable;
`ifdef PIXEL_WRITE_FIFO_Z_EN
  logic [28:0]        ent_z_address;
  logic [63:0]        ent_z;
  logic               ent_z_write;

  assign fifo_data = {z_write, pixel_active, z, z_address, color, color_address};
`else
  logic               unused_z_inputs;

  assign unused_z_inputs = ^{z_write, z_address, z};
  assign fifo_data       = {pixel_active, color, color_address};
`endif

  assign fetch_active = fifo_q[ACTIVE_LSB +: 2];
  assign idle         = fifo_empty && (state == S_IDLE);

  pixel_entry_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (fifo_data),
    .wrreq   (enqueue),
    .rdreq   (fifo_rdreq),
    .q       (fifo_q),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .usedw   (size)
  );

  // Sticky flag: an entry was offered while there was no room for it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else if (enqueue && fifo_full) overflow <= 1'b1;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end

  // Next state and FIFO read; the last accept of an entry reads the next one directly
  always_comb begin
    state_nxt  = state;
    fifo_rdreq = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = (fetch_active == 2'b00) ? S_IDLE : S_COLOR;
      end
      S_COLOR: begin
        if (!write_waitrequest) begin
`ifdef PIXEL_WRITE_FIFO_Z_EN
          if (ent_z_write) begin
            state_nxt = S_Z;
          end else if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
`else
          if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
`endif
        end
      end
`ifdef PIXEL_WRITE_FIFO_Z_EN
      S_Z: begin
        if (!write_waitrequest) begin
          if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the entry delivered by the FIFO read issued in the previous cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_color_address <= '0;
      ent_color         <= '0;
      ent_byteenable    <= '0;
`ifdef PIXEL_WRITE_FIFO_Z_EN
      ent_z_address     <= '0;
      ent_z             <= '0;
      ent_z_write       <= 1'b0;
`endif
    end else if (state == S_FETCH) begin
      ent_color_address <= fifo_q[CADDR_LSB +: ADDR_W];
      ent_color         <= fifo_q[COLOR_LSB +: PAIR_W];
      ent_byteenable    <= byteenable_from_active(fetch_active);
`ifdef PIXEL_WRITE_FIFO_Z_EN
      ent_z_address     <= fifo_q[ZADDR_LSB +: ADDR_W];
      ent_z             <= fifo_q[Z_LSB +: PAIR_W];
      ent_z_write       <= fifo_q[ZWRITE_LSB];
`endif
    end
  end

  // Avalon master outputs come straight from the latched entry, so they stay stable under waitrequest
  always_comb begin
    write_write      = (state == S_COLOR) || (state == S_Z);
    write_address    = ent_color_address;
    write_writedata  = ent_color;
    write_byteenable = ent_byteenable;
`ifdef PIXEL_WRITE_FIFO_Z_EN
    if (state == S_Z) begin
      write_address   = ent_z_address;
      write_writedata = ent_z;
    end
`endif
  end

endmodule
